// File: rtl/mcu_bus_bridge.sv
// MCU-to-peripheral bus bridge: decodes CPU transfers onto N_SLV APB-style slave channels.
// Optional ACCESS-phase timeout is enabled with `define BUS_TIMEOUT_EN.
`timescale 1ns/1ps
module mcu_bus_bridge #(
  parameter int unsigned N_SLV      = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned SLV_ADDR_W = 12,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    busReq,
  input  logic                    busWe,
  input  logic [ADDR_W-1:0]       busAddr,
  input  logic [31:0]             busWData,
  input  logic [1:0]              LSControl,
  input  logic                    SignControl,
  output logic [31:0]             busRData,
  output logic                    busReady,
  output logic                    busErr,
  output logic [N_SLV-1:0]        psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [SLV_ADDR_W-1:0]   paddr,
  output logic [31:0]             pwdata,
  output logic [3:0]              pstrb,
  input  logic [N_SLV*32-1:0]     prdata,
  input  logic [N_SLV-1:0]        pready
);

  localparam int unsigned IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 0;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned CNT_W = 10;

  if (N_SLV < 1 || N_SLV > 8) begin : gBadNSlv
    $error("mcu_bus_bridge: N_SLV must be 1..8");
  end
  if (TIMEOUT < 2 || TIMEOUT > 1023) begin : gBadTimeout
    $error("mcu_bus_bridge: TIMEOUT must be 2..1023");
  end

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, DONE, ERR} stateT;

  stateT            state;
  logic [1:0]       lsReg;
  logic             signReg;
  logic [1:0]       aLoReg;
  logic [SEL_W-1:0] idxReg;
`ifdef BUS_TIMEOUT_EN
  logic [CNT_W-1:0] toCnt;
`endif

  // Request decode: slave index, error detection, lane strobes and replicated write data
  logic [ADDR_W-1:0] idxField;
  logic [ADDR_W-1:0] upperField;
  logic [SEL_W-1:0]  reqIdx;
  logic              decErr;
  logic [3:0]        reqStrb;
  logic [31:0]       reqWData;
  logic [N_SLV-1:0]  reqOneHot;

  always_comb begin
    idxField   = (busAddr >> SLV_ADDR_W) & ADDR_W'((64'd1 << IDX_W) - 64'd1);
    upperField = busAddr >> (SLV_ADDR_W + IDX_W);
    reqIdx     = SEL_W'(idxField);
    decErr     = (reqIdx >= SEL_W'(N_SLV)) || (upperField != '0) ||
                 (LSControl == 2'b11) ||
                 ((LSControl == 2'b01) && busAddr[0]) ||
                 ((LSControl == 2'b10) && (busAddr[1:0] != 2'b00));
    reqStrb    = 4'b0000;
    reqWData   = busWData;
    case (LSControl)
      2'b00: begin
        reqStrb  = 4'b0001 << busAddr[1:0];
        reqWData = {4{busWData[7:0]}};
      end
      2'b01: begin
        reqStrb  = busAddr[1] ? 4'b1100 : 4'b0011;
        reqWData = {2{busWData[15:0]}};
      end
      2'b10: reqStrb = 4'b1111;
      default: reqStrb = 4'b0000;
    endcase
    reqOneHot = '0;
    for (int i = 0; i < int'(N_SLV); i++) begin
      reqOneHot[i] = (reqIdx == SEL_W'(i));
    end
  end

  // Selected slave response; unselected pready/prdata never reach the FSM
  logic        selReady;
  logic [31:0] selData;

  always_comb begin
    selReady = 1'b0;
    selData  = 32'h0;
    for (int i = 0; i < int'(N_SLV); i++) begin
      if (idxReg == SEL_W'(i)) begin
        selReady = pready[i];
        selData  = prdata[32*i +: 32];
      end
    end
  end

  // Read lane extraction, shifted to bit 0 and extended per the latched sign control
  logic [7:0]  rdByte;
  logic [15:0] rdHalf;
  logic [31:0] rdExt;

  always_comb begin
    case (aLoReg)
      2'd0:    rdByte = selData[7:0];
      2'd1:    rdByte = selData[15:8];
      2'd2:    rdByte = selData[23:16];
      default: rdByte = selData[31:24];
    endcase
    rdHalf = aLoReg[1] ? selData[31:16] : selData[15:0];
    case (lsReg)
      2'b00:   rdExt = {{24{signReg & rdByte[7]}}, rdByte};
      2'b01:   rdExt = {{16{signReg & rdHalf[15]}}, rdHalf};
      default: rdExt = selData;
    endcase
  end

  // Transfer FSM; every output is registered alongside the state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      lsReg    <= 2'b00;
      signReg  <= 1'b0;
      aLoReg   <= 2'b00;
      idxReg   <= '0;
      busRData <= 32'h0;
      busReady <= 1'b0;
      busErr   <= 1'b0;
      psel     <= '0;
      penable  <= 1'b0;
      pwrite   <= 1'b0;
      paddr    <= '0;
      pwdata   <= 32'h0;
      pstrb    <= 4'b0000;
`ifdef BUS_TIMEOUT_EN
      toCnt    <= '0;
`endif
    end else begin
      busReady <= 1'b0;
      busErr   <= 1'b0;
      case (state)
        IDLE: begin
          if (busReq) begin
            pwrite  <= busWe;
            paddr   <= busAddr[SLV_ADDR_W-1:0];
            pwdata  <= reqWData;
            pstrb   <= reqStrb;
            lsReg   <= LSControl;
            signReg <= SignControl;
            aLoReg  <= busAddr[1:0];
            idxReg  <= reqIdx;
            if (decErr) begin
              state    <= ERR;
              busReady <= 1'b1;
              busErr   <= 1'b1;
            end else begin
              state   <= SETUP;
              psel    <= reqOneHot;
              penable <= 1'b0;
            end
          end
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
`ifdef BUS_TIMEOUT_EN
          toCnt   <= '0;
`endif
        end
        ACCESS: begin
          if (selReady) begin
            state    <= DONE;
            busReady <= 1'b1;
            psel     <= '0;
            penable  <= 1'b0;
            if (!pwrite) busRData <= rdExt;
          end
`ifdef BUS_TIMEOUT_EN
          else if (toCnt == CNT_W'(TIMEOUT - 1)) begin
            state    <= ERR;
            busReady <= 1'b1;
            busErr   <= 1'b1;
            psel     <= '0;
            penable  <= 1'b0;
          end else begin
            toCnt <= toCnt + CNT_W'(1);
          end
`endif
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mcu_bus_bridge.md
MCU_BUS_BRIDGE -- requirements
Module: mcu_bus_bridge

Interface
REQ-001 Parameters SHALL be:
- N_SLV, 4: slave channel count, 1..8.
- ADDR_W, 32: bus address width.
- SLV_ADDR_W, 12: log2 of the byte window per slave.
- TIMEOUT, 64: maximum ACCESS cycles, 2..1023.
REQ-002 Ports SHALL be:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- busReq  in  1  CPU transfer request.
- busWe  in  1  1=write, 0=read.
- busAddr  in  ADDR_W  byte address.
- busWData  in  32  write data, right-aligned.
- LSControl  in  2  transfer size: 00 byte, 01 half, 10 word, 11 illegal.
- SignControl  in  1  1=sign-extend read data.
- busRData  out  32  read data.
- busReady  out  1  one-cycle completion pulse.
- busErr  out  1  error flag, valid with busReady.
- psel  out  N_SLV  one-hot slave select.
- penable  out  1  access phase.
- pwrite  out  1  write strobe.
- paddr  out  SLV_ADDR_W  in-window byte address.
- pwdata  out  32  lane-aligned write data.
- pstrb  out  4  byte-lane enables.
- prdata  in  N_SLV*32  slave read data; slave i occupies bits [32i+31:32i].
- pready  in  N_SLV  slave ready.

Function
REQ-003 FSM states SHALL be IDLE, SETUP, ACCESS, DONE, ERR.
REQ-004 In IDLE, busReq=1 SHALL latch busWe, busAddr, busWData, LSControl and SignControl; the CPU holds these stable until busReady.
REQ-005 Slave index SHALL be busAddr[SLV_ADDR_W +: clog2(N_SLV)], with clog2(1)=0.
REQ-006 A decode error SHALL be any of: index >= N_SLV; nonzero address bits above the index field; LSControl=11; half access with addr[0]=1; word access with addr[1:0]!=0.
REQ-007 Next state from IDLE SHALL be ERR on decode error, else SETUP; busReq outside IDLE SHALL be ignored.
REQ-008 SETUP SHALL drive psel one-hot and penable=0, then go unconditionally to ACCESS.
REQ-009 ACCESS SHALL hold psel and drive penable=1; go to DONE on pready[index]=1, otherwise stay.
REQ-010 DONE and ERR SHALL each last one cycle, assert busReady=1, then return to IDLE; busErr=1 in ERR only.
REQ-011 Minimum latency SHALL be 3 cycles: request sampled at edge k, busReady high during cycle k+3.
REQ-012 pstrb SHALL be:
- byte: 1<<addr[1:0].
- half: 0011 for addr[1]=0, 1100 for addr[1]=1.
- word: 1111.
pwdata SHALL replicate the byte or half across all lanes; pstrb SHALL be driven for reads too.
REQ-013 On a read completing in DONE, busRData SHALL be registered as the selected lane(s) shifted to bit 0, sign- or zero-extended per SignControl.
REQ-014 busRData SHALL hold until the next successful read completes; writes and errors SHALL leave it unchanged.
REQ-015 Outside SETUP and ACCESS, psel=0 and penable=0; pwrite, paddr and pwdata SHALL hold their latched values.
REQ-016 pready of unselected slaves SHALL be ignored.

Reset
REQ-017 reset=0 SHALL asynchronously force IDLE, including mid-transfer.
REQ-018 Under reset: busReady=0, busErr=0, busRData=0, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0, timeout counter=0.
REQ-019 A transfer aborted by reset SHALL never produce busReady.

Configuration
REQ-020 With BUS_TIMEOUT_EN defined, a counter SHALL clear on entering ACCESS and increment each ACCESS cycle.
REQ-021 With BUS_TIMEOUT_EN defined, when the counter reaches TIMEOUT-1 without pready, the next state SHALL be ERR: psel drops, busErr=1.
REQ-022 Without BUS_TIMEOUT_EN, no counter SHALL exist and ACCESS SHALL wait indefinitely.

Verification
REQ-023 Word read, N_SLV=4, addr 0x0000_1004, prdata slice1=0xDEAD_BEEF, pready immediate -> psel=0010, paddr=0x004, busRData=0xDEADBEEF, busReady in cycle k+3, busErr=0.
REQ-024 Byte write, addr 0x0000_0003, wdata 0x0000_00A5 -> pstrb=1000, pwdata=0xA5A5A5A5, pwrite=1, busErr=0.
REQ-025 Signed half read, addr 0x2002, slice2=0x8001_0000, SignControl=1 -> busRData=0xFFFF8001; same read with SignControl=0 -> 0x00008001.
REQ-026 Word access at 0x1002, and any access at 0x0001_0000 -> ERR, busReady=busErr=1 in cycle k+1, psel never asserted.
REQ-027 BUS_TIMEOUT_EN, TIMEOUT=8, pready held 0 -> exactly 8 ACCESS cycles, then busErr=1; without BUS_TIMEOUT_EN -> still in ACCESS after 1000 cycles.
REQ-028 reset pulsed low during ACCESS -> all outputs 0 immediately, no busReady; next request completes normally.
